// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared types for the PWM ramp sequencer: FSM state encoding and default widths.
package pwm_ramp_ctrl_pkg;

  localparam int PWMC_WIDTH_DEF      = 4;
  localparam int PWMC_HOLD_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    PWMC_IDLE = 2'd0,
    PWMC_ARM  = 2'd1,
    PWMC_RAMP = 2'd2
  } pwmc_state_t;

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Command port of the PWM ramp sequencer: one valid/ready channel plus an abort strobe.
interface pwm_ramp_ctrl_if #(
    parameter int WIDTH      = 4,
    parameter int HOLD_WIDTH = 8
);
    // A command transfers on a posedge with cmd_valid && cmd_ready; fields are only sampled then.
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [WIDTH-1:0]      cmd_wave_length;
    logic [WIDTH-1:0]      cmd_target;
    logic [WIDTH-1:0]      cmd_step;
    logic [HOLD_WIDTH-1:0] cmd_hold;
    logic                  abort;

    modport master (
        output cmd_valid, cmd_wave_length, cmd_target, cmd_step, cmd_hold, abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_wave_length, cmd_target, cmd_step, cmd_hold, abort,
        output cmd_ready
    );
endinterface

// File: rtl/pwm_step_calc.sv
// Saturating one-step move of a PWM high_time toward a target; never overshoots or wraps.
module pwm_step_calc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] next,
    output logic             at_target
);
    logic [WIDTH:0] gap_up;
    logic [WIDTH:0] gap_dn;

    // Gaps are taken one bit wider so the compare against step cannot wrap.
    assign gap_up = {1'b0, target} - {1'b0, cur};
    assign gap_dn = {1'b0, cur} - {1'b0, target};

    always_comb begin
        next = cur;
        if (step == '0) begin
            next = target;
        end else if (cur < target) begin
            next = (gap_up <= {1'b0, step}) ? target : cur + step;
        end else if (cur > target) begin
            next = (gap_dn <= {1'b0, step}) ? target : cur - step;
        end
    end

    assign at_target = (next == target);
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps a pwm's high_time toward a commanded target, updating only on pwm period boundaries.
module pwm_ramp_ctrl
    import pwm_ramp_ctrl_pkg::*;
#(
    parameter int WIDTH      = PWMC_WIDTH_DEF,
    parameter int HOLD_WIDTH = PWMC_HOLD_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    pwm_ramp_ctrl_if.slave    cmd,
    input  logic              pwm_last_cycle,
    output logic [WIDTH-1:0]  pwm_wave_length,
    output logic [WIDTH-1:0]  pwm_high_time,
    output logic              busy,
    output logic              done,
    output pwmc_state_t       state_dbg
);
    pwmc_state_t           state;
    pwmc_state_t           state_nxt;
    logic [WIDTH-1:0]      lat_wave;
    logic [WIDTH-1:0]      lat_target;
    logic [WIDTH-1:0]      lat_step;
    logic [HOLD_WIDTH-1:0] lat_hold;
    logic [HOLD_WIDTH-1:0] hold_cnt;
    logic [WIDTH-1:0]      next_high;
    logic                  at_target;
    logic                  update;
    logic                  load_wave;
    logic                  hold_dec;
    logic                  accept;

    pwm_step_calc #(.WIDTH(WIDTH)) u_step (
        .cur       (pwm_high_time),
        .target    (lat_target),
        .step      (lat_step),
        .next      (next_high),
        .at_target (at_target)
    );

    assign accept    = cmd.cmd_valid && cmd.cmd_ready;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= PWMC_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            PWMC_IDLE: if (cmd.cmd_valid) state_nxt = PWMC_ARM;
            PWMC_ARM, PWMC_RAMP: begin
                if (cmd.abort)   state_nxt = PWMC_IDLE;
                else if (update) state_nxt = at_target ? PWMC_IDLE : PWMC_RAMP;
            end
            default:             state_nxt = PWMC_IDLE;
        endcase
    end

    // Abort has priority over a coincident period boundary: that edge applies nothing.
    always_comb begin
        cmd.cmd_ready = (state == PWMC_IDLE);
        busy          = (state != PWMC_IDLE);
        update        = 1'b0;
        load_wave     = 1'b0;
        hold_dec      = 1'b0;
        unique case (state)
            PWMC_ARM: begin
                if (!cmd.abort && pwm_last_cycle) begin
                    update    = 1'b1;
                    load_wave = 1'b1;
                end
            end
            PWMC_RAMP: begin
                if (!cmd.abort && pwm_last_cycle) begin
                    if (hold_cnt <= HOLD_WIDTH'(1)) update   = 1'b1;
                    else                            hold_dec = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_wave        <= '0;
            lat_target      <= '0;
            lat_step        <= '0;
            lat_hold        <= '0;
            hold_cnt        <= '0;
            pwm_wave_length <= '0;
            pwm_high_time   <= '0;
            done            <= 1'b0;
        end else begin
            done <= update && at_target;
            if (accept) begin
                lat_wave   <= cmd.cmd_wave_length;
                lat_target <= cmd.cmd_target;
                lat_step   <= cmd.cmd_step;
                lat_hold   <= (cmd.cmd_hold == '0) ? HOLD_WIDTH'(1) : cmd.cmd_hold;
            end
            if (load_wave) pwm_wave_length <= lat_wave;
            if (update) begin
                pwm_high_time <= next_high;
                hold_cnt      <= lat_hold;
            end else if (hold_dec) begin
                hold_cnt <= hold_cnt - HOLD_WIDTH'(1);
            end
        end
    end
endmodule
